bg_frame_sequencer: RTL and testbench

Frame-level control unit for the background-removal array. It sequences a bank of `pe` processing elements through two phases: a summation pass, then a background-replace pass. Between the phases it reduces the per-PE colour sums to a mean background colour and drives that mean onto the PEs' `red_exp`/`green_exp`/`blue_exp` inputs. It owns every `Start_Sum`, `Start_BgRemoval` and `Ack` strobe in the array and reports frame completion or timeout to the host.

---
 rtl/bg_frame_sequencer_pkg.sv | 44 ++++
 rtl/bg_frame_sequencer_mean_accum.sv | 85 ++++++++
 rtl/bg_frame_sequencer.sv | 131 +++++++++++++
 tb/tb_bg_frame_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bg_frame_sequencer_pkg.sv
// Shared definitions for the background-removal frame sequencer.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package bg_frame_sequencer_pkg;

  // Bit positions of the one-hot state vector
  localparam int ST_IDLE      = 0;
  localparam int ST_SUM_START = 1;
  localparam int ST_SUM_WAIT  = 2;
  localparam int ST_ACCUM     = 3;
  localparam int ST_MEAN      = 4;
  localparam int ST_SUM_ACK   = 5;
  localparam int ST_BG_START  = 6;
  localparam int ST_BG_WAIT   = 7;
  localparam int ST_BG_ACK    = 8;
  localparam int ST_FIN       = 9;
  localparam int ST_ABORT     = 10;
  localparam int NUM_ST       = 11;

  typedef enum logic [NUM_ST-1:0] {
    IDLE      = 11'b000_0000_0001,
    SUM_START = 11'b000_0000_0010,
    SUM_WAIT  = 11'b000_0000_0100,
    ACCUM     = 11'b000_0000_1000,
    MEAN      = 11'b000_0001_0000,
    SUM_ACK   = 11'b000_0010_0000,
    BG_START  = 11'b000_0100_0000,
    BG_WAIT   = 11'b000_1000_0000,
    BG_ACK    = 11'b001_0000_0000,
    FIN       = 11'b010_0000_0000,
    ABORT     = 11'b100_0000_0000
  } seq_state_t;

  // Ceiling log2, used for counter widths and the mean shift
  function automatic int log2_f(input int v);
    return $clog2(v);
  endfunction

  // Width of one PE's per-colour sum slice (SUM_W)
  function automatic int sum_w(input int pix_per_pe);
    return 8 * pix_per_pe;
  endfunction

endpackage

// File: rtl/bg_frame_sequencer_mean_accum.sv
// Walks the PE sum slices, accumulates each colour and divides by pixel count.
// Latency: NUM_PE add cycles, then one load cycle to the registered *_exp.
// Backpressure: none; driven purely by clr/add/load strobes from the FSM.
module bg_mean_accum
  import bg_frame_sequencer_pkg::*;
#(
  parameter int NUM_PE     = 4,
  parameter int PIX_PER_PE = 1
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic                              clr,
  input  logic                              add,
  input  logic                              load,
  input  logic [NUM_PE*8*PIX_PER_PE-1:0]    red_sum_all,
  input  logic [NUM_PE*8*PIX_PER_PE-1:0]    green_sum_all,
  input  logic [NUM_PE*8*PIX_PER_PE-1:0]    blue_sum_all,
  output logic                              last,
  output logic [7:0]                        red_exp,
  output logic [7:0]                        green_exp,
  output logic [7:0]                        blue_exp
);

  localparam int SUM_W = sum_w(PIX_PER_PE);
  localparam int SH    = log2_f(NUM_PE * PIX_PER_PE);
  localparam int ACC_W = 8 + SH;
  localparam int IDX_W = (NUM_PE > 1) ? log2_f(NUM_PE) : 1;

  logic [IDX_W-1:0] idx;
  logic [ACC_W-1:0] red_acc, green_acc, blue_acc;
  logic [ACC_W-1:0] red_shf, green_shf, blue_shf;
  logic [7:0]       red_b   [NUM_PE];
  logic [7:0]       green_b [NUM_PE];
  logic [7:0]       blue_b  [NUM_PE];

  // Only the low byte of each PE slice contributes to the mean
  for (genvar k = 0; k < NUM_PE; k++) begin : g_slice
    assign red_b[k]   = red_sum_all[k*SUM_W +: 8];
    assign green_b[k] = green_sum_all[k*SUM_W +: 8];
    assign blue_b[k]  = blue_sum_all[k*SUM_W +: 8];
  end

  assign last = (idx == IDX_W'(NUM_PE - 1));

  // Power-of-two pixel count, so the divide is a plain shift
  always_comb begin
    red_shf   = red_acc >> SH;
    green_shf = green_acc >> SH;
    blue_shf  = blue_acc >> SH;
  end

  // Accumulators and PE index: cleared per frame, one PE per add cycle
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idx       <= '0;
      red_acc   <= '0;
      green_acc <= '0;
      blue_acc  <= '0;
    end else if (clr) begin
      idx       <= '0;
      red_acc   <= '0;
      green_acc <= '0;
      blue_acc  <= '0;
    end else if (add) begin
      idx       <= last ? '0 : idx + IDX_W'(1);
      red_acc   <= red_acc + ACC_W'(red_b[idx]);
      green_acc <= green_acc + ACC_W'(green_b[idx]);
      blue_acc  <= blue_acc + ACC_W'(blue_b[idx]);
    end
  end

  // Mean colour registers: loaded once per completed sum phase, held otherwise
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      red_exp   <= '0;
      green_exp <= '0;
      blue_exp  <= '0;
    end else if (load) begin
      red_exp   <= red_shf[7:0];
      green_exp <= green_shf[7:0];
      blue_exp  <= blue_shf[7:0];
    end
  end

endmodule

// File: rtl/bg_frame_sequencer.sv
// Frame controller: sum pass, mean reduction, background-replace pass, done/abort.
// Latency: Start to Done = 2w + NUM_PE + 7 cycles for PEs finishing w cycles after each strobe.
// Backpressure: Start is ignored while Busy; wait states abort after TIMEOUT cycles.
module bg_frame_sequencer
  import bg_frame_sequencer_pkg::*;
#(
  parameter int NUM_PE     = 4,
  parameter int PIX_PER_PE = 1,
  parameter int TIMEOUT    = 1024
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic                              Start,
  input  logic [NUM_PE-1:0]                 sum_done,
  input  logic [NUM_PE-1:0]                 bg_done,
  input  logic [NUM_PE*8*PIX_PER_PE-1:0]    red_sum_all,
  input  logic [NUM_PE*8*PIX_PER_PE-1:0]    green_sum_all,
  input  logic [NUM_PE*8*PIX_PER_PE-1:0]    blue_sum_all,
  output logic                              Start_Sum,
  output logic                              Start_BgRemoval,
  output logic                              Ack,
  output logic [7:0]                        red_exp,
  output logic [7:0]                        green_exp,
  output logic [7:0]                        blue_exp,
  output logic                              Busy,
  output logic                              Done,
  output logic                              Err
);

  localparam int TMR_W = (TIMEOUT > 1) ? log2_f(TIMEOUT) : 1;

  seq_state_t       state, state_nxt;
  logic [TMR_W-1:0] timer;
  logic             tmo;
  logic             acc_clr, acc_add, acc_load, acc_last;

  assign tmo = (timer == TMR_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode plus accumulator control; completion beats timeout
  always_comb begin
    state_nxt = state;
    acc_clr   = 1'b0;
    acc_add   = 1'b0;
    acc_load  = 1'b0;
    case (state)
      IDLE:      if (Start) state_nxt = SUM_START;
      SUM_START: begin
        acc_clr   = 1'b1;
        state_nxt = SUM_WAIT;
      end
      SUM_WAIT: begin
        if (&sum_done) state_nxt = ACCUM;
        else if (tmo)  state_nxt = ABORT;
      end
      ACCUM: begin
        acc_add = 1'b1;
        if (acc_last) state_nxt = MEAN;
      end
      MEAN: begin
        acc_load  = 1'b1;
        state_nxt = SUM_ACK;
      end
      SUM_ACK:   state_nxt = BG_START;
      BG_START:  state_nxt = BG_WAIT;
      BG_WAIT: begin
        if (&bg_done) state_nxt = BG_ACK;
        else if (tmo) state_nxt = ABORT;
      end
      BG_ACK:    state_nxt = FIN;
      FIN:       state_nxt = IDLE;
      ABORT:     state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Wait-state timer: zeroed by the start states, saturates at TIMEOUT-1
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      timer <= '0;
    end else if (state == SUM_START || state == BG_START) begin
      timer <= '0;
    end else if ((state == SUM_WAIT || state == BG_WAIT) && !tmo) begin
      timer <= timer + TMR_W'(1);
    end
  end

  // Registered strobes decoded from the next state so they align with it
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Start_Sum       <= 1'b0;
      Start_BgRemoval <= 1'b0;
      Ack             <= 1'b0;
      Busy            <= 1'b0;
      Done            <= 1'b0;
      Err             <= 1'b0;
    end else begin
      Start_Sum       <= (state_nxt == SUM_START);
      Start_BgRemoval <= (state_nxt == BG_START);
      Ack             <= (state_nxt == SUM_ACK) || (state_nxt == BG_ACK) ||
                         (state_nxt == ABORT);
      Busy            <= (state_nxt != IDLE);
      Done            <= (state_nxt == FIN);
      Err             <= (state_nxt == ABORT);
    end
  end

  bg_mean_accum #(
    .NUM_PE     (NUM_PE),
    .PIX_PER_PE (PIX_PER_PE)
  ) u_mean (
    .Clk           (Clk),
    .Reset         (Reset),
    .clr           (acc_clr),
    .add           (acc_add),
    .load          (acc_load),
    .red_sum_all   (red_sum_all),
    .green_sum_all (green_sum_all),
    .blue_sum_all  (blue_sum_all),
    .last          (acc_last),
    .red_exp       (red_exp),
    .green_exp     (green_exp),
    .blue_exp      (blue_exp)
  );

endmodule

// File: tb/tb_bg_frame_sequencer.sv
// Self-checking bench for bg_frame_sequencer with a behavioural PE model.
// Latency: expected frame timing derived from the per-phase cycle budget.
// Backpressure: PE done flags delayed by a configurable number of cycles.
module tb_bg_frame_sequencer;

  localparam int N    = 4;
  localparam int PIX  = 1;
  localparam int TMO  = 32;
  localparam int SW   = 8 * PIX;
  localparam int BUSW = N * SW;

  logic            Clk = 1'b0;
  logic            Reset;
  logic            Start;
  logic [N-1:0]    sum_done, bg_done;
  logic [BUSW-1:0] red_sum_all, green_sum_all, blue_sum_all;
  logic            Start_Sum, Start_BgRemoval, Ack, Busy, Done, Err;
  logic [7:0]      red_exp, green_exp, blue_exp;

  bg_frame_sequencer #(.NUM_PE(N), .PIX_PER_PE(PIX), .TIMEOUT(TMO)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .sum_done(sum_done), .bg_done(bg_done),
    .red_sum_all(red_sum_all), .green_sum_all(green_sum_all), .blue_sum_all(blue_sum_all),
    .Start_Sum(Start_Sum), .Start_BgRemoval(Start_BgRemoval), .Ack(Ack),
    .red_exp(red_exp), .green_exp(green_exp), .blue_exp(blue_exp),
    .Busy(Busy), .Done(Done), .Err(Err)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // PE model: done flags rise w cycles after the strobe, drop on Ack
  int           pe_ws = 1, pe_wb = 1;
  logic [N-1:0] sum_mask = '1, bg_mask = '1;
  int           sum_cnt = 0, bg_cnt = 0;

  always @(negedge Clk) begin
    if (Reset) begin
      sum_done = '0; bg_done = '0; sum_cnt = 0; bg_cnt = 0;
    end else begin
      if (sum_cnt > 0) begin sum_cnt--; if (sum_cnt == 0) sum_done = sum_mask; end
      if (bg_cnt > 0)  begin bg_cnt--;  if (bg_cnt == 0)  bg_done  = bg_mask;  end
      if (Start_Sum)       sum_cnt = pe_ws;
      if (Start_BgRemoval) bg_cnt  = pe_wb;
      if (Ack) begin sum_done = '0; bg_done = '0; sum_cnt = 0; bg_cnt = 0; end
    end
  end

  // Strobe totals and over-long pulse detection
  int   n_ss = 0, n_ack = 0, n_done = 0, n_err = 0, n_wide = 0;
  logic p_ss = 0, p_sbg = 0, p_ack = 0, p_done = 0, p_err = 0;

  always @(negedge Clk) begin
    if (!Reset) begin
      n_ss   += int'(Start_Sum);
      n_ack  += int'(Ack);
      n_done += int'(Done);
      n_err  += int'(Err);
      n_wide += int'(Start_Sum & p_ss) + int'(Start_BgRemoval & p_sbg) +
                int'(Ack & p_ack) + int'(Done & p_done) + int'(Err & p_err);
    end
    p_ss = Start_Sum; p_sbg = Start_BgRemoval; p_ack = Ack; p_done = Done; p_err = Err;
  end

  // Latency counts cycles inclusively, from the cycle Start is high to the Done/Err cycle
  task automatic run_frame(input logic [BUSW-1:0] rs, gs, bs, input int ws, wb,
                           input logic sfull, bfull, input int restart,
                           output int lat, output logic got_done, got_err,
                           output int d_ss, d_ack, d_done, d_err, d_wide, gaps);
    int s_ss, s_ack, s_done, s_err, s_wide;
    red_sum_all = rs; green_sum_all = gs; blue_sum_all = bs;
    pe_ws = ws; pe_wb = wb;
    sum_mask = sfull ? '1 : N'(4'b0111);
    bg_mask  = bfull ? '1 : N'(4'b0111);
    @(negedge Clk);
    s_ss = n_ss; s_ack = n_ack; s_done = n_done; s_err = n_err; s_wide = n_wide;
    Start = 1'b1; lat = 1; got_done = 1'b0; got_err = 1'b0; gaps = 0;
    while (lat < 400) begin
      @(negedge Clk);
      lat++;
      Start = (lat == restart);
      if (!Busy) gaps++;
      if (Done || Err) begin got_done = Done; got_err = Err; break; end
    end
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    d_ss = n_ss - s_ss; d_ack = n_ack - s_ack; d_done = n_done - s_done;
    d_err = n_err - s_err; d_wide = n_wide - s_wide;
  endtask

  typedef struct packed {
    logic [BUSW-1:0] rs, gs, bs;
    logic [7:0]      ws, wb, restart;
    logic            sfull, bfull;
    logic [7:0]      er, eg, eb;
    logic            eerr;
    logic [7:0]      elat, eack;
  } vec_t;

  vec_t vecs [6];

  // Reference mean: average of each PE's low byte, truncated
  function automatic logic [7:0] mean8(input logic [BUSW-1:0] s);
    int acc = 0;
    for (int k = 0; k < N; k++) acc += int'(s[k*SW +: 8]);
    return 8'(acc / (N * PIX));
  endfunction

  task automatic check_frame(input string tag, input vec_t v);
    int lat, d_ss, d_ack, d_done, d_err, d_wide, gaps;
    logic gd, ge;
    run_frame(v.rs, v.gs, v.bs, int'(v.ws), int'(v.wb), v.sfull, v.bfull, int'(v.restart),
              lat, gd, ge, d_ss, d_ack, d_done, d_err, d_wide, gaps);
    check({tag, " latency"},   lat,        v.elat);
    check({tag, " done"},      gd,         !v.eerr);
    check({tag, " err"},       ge,         v.eerr);
    check({tag, " red_exp"},   red_exp,    v.er);
    check({tag, " green_exp"}, green_exp,  v.eg);
    check({tag, " blue_exp"},  blue_exp,   v.eb);
    check({tag, " start_sum"}, d_ss,       1);
    check({tag, " ack"},       d_ack,      v.eack);
    check({tag, " done_cnt"},  d_done,     !v.eerr);
    check({tag, " err_cnt"},   d_err,      v.eerr);
    check({tag, " pulse_len"}, d_wide,     0);
    check({tag, " busy_gap"},  gaps,       0);
    check({tag, " idle"},      Busy,       0);
  endtask

  logic [7:0] m_r, m_g, m_b;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    Reset = 1'b1; Start = 1'b0;
    red_sum_all = '0; green_sum_all = '0; blue_sum_all = '0;
    repeat (2) @(negedge Clk);
    check("rst busy", Busy, 0);
    check("rst strobes", {Start_Sum, Start_BgRemoval, Ack, Done, Err}, 0);
    check("rst exp", {red_exp, green_exp, blue_exp}, 0);
    Reset = 1'b0;
    @(negedge Clk);

    // Directed frames with hand-derived expectations
    vecs[0] = '{rs:{8'd40,8'd30,8'd20,8'd10}, gs:{8'd8,8'd8,8'd8,8'd8}, bs:{8'd4,8'd0,8'd0,8'd0},
                ws:3, wb:3, restart:0, sfull:1, bfull:1, er:25, eg:8, eb:1, eerr:0, elat:17, eack:2};
    vecs[1] = '{rs:'1, gs:'1, bs:'1,
                ws:3, wb:3, restart:0, sfull:1, bfull:1, er:255, eg:255, eb:255, eerr:0, elat:17, eack:2};
    vecs[2] = '{rs:{4{8'd100}}, gs:{4{8'd100}}, bs:{4{8'd100}},
                ws:3, wb:3, restart:0, sfull:0, bfull:1, er:255, eg:255, eb:255, eerr:1, elat:TMO+3, eack:1};
    vecs[3] = '{rs:{8'd6,8'd3,8'd2,8'd1}, gs:{4{8'd100}}, bs:{8'd0,8'd0,8'd0,8'd7},
                ws:1, wb:TMO, restart:0, sfull:1, bfull:1, er:3, eg:100, eb:1, eerr:0, elat:1+TMO+N+7, eack:2};
    vecs[4] = '{rs:{8'd44,8'd40,8'd40,8'd40}, gs:'0, bs:{8'd203,8'd202,8'd201,8'd200},
                ws:2, wb:TMO+1, restart:0, sfull:1, bfull:1, er:41, eg:0, eb:201, eerr:1, elat:2+N+TMO+6, eack:2};
    vecs[5] = '{rs:{8'd80,8'd70,8'd60,8'd50}, gs:{8'd0,8'd0,8'd0,8'd255}, bs:{4{8'd9}},
                ws:2, wb:6, restart:14, sfull:1, bfull:1, er:65, eg:63, eb:9, eerr:0, elat:19, eack:2};
    for (int i = 0; i < 6; i++) check_frame($sformatf("vec%0d", i), vecs[i]);
    m_r = vecs[5].er; m_g = vecs[5].eg; m_b = vecs[5].eb;

    // Randomized frames against the phase-level model
    for (int i = 0; i < 16; i++) begin
      v = '0;
      v.rs = BUSW'($urandom); v.gs = BUSW'($urandom); v.bs = BUSW'($urandom);
      v.ws = 8'($urandom_range(1, TMO + 2));
      v.wb = 8'($urandom_range(1, TMO + 2));
      v.sfull = 1'b1; v.bfull = 1'b1;
      if (int'(v.ws) > TMO) begin
        v.eerr = 1'b1; v.elat = 8'(TMO + 3); v.eack = 1;
      end else begin
        m_r = mean8(v.rs); m_g = mean8(v.gs); m_b = mean8(v.bs);
        v.eack = 2;
        if (int'(v.wb) > TMO) begin
          v.eerr = 1'b1; v.elat = 8'(int'(v.ws) + N + TMO + 6);
        end else begin
          v.eerr = 1'b0; v.elat = 8'(int'(v.ws) + int'(v.wb) + N + 7);
        end
      end
      v.er = m_r; v.eg = m_g; v.eb = m_b;
      check_frame($sformatf("rnd%0d", i), v);
    end

    // Reset while the accumulator is walking the PEs
    begin
      int s_ack;
      red_sum_all = {4{8'd200}}; green_sum_all = {4{8'd100}}; blue_sum_all = {4{8'd50}};
      pe_ws = 2; pe_wb = 2; sum_mask = '1; bg_mask = '1;
      @(negedge Clk);
      s_ack = n_ack;
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      repeat (4) @(negedge Clk);
      check("accum busy", Busy, 1);
      Reset = 1'b1;
      #1;
      check("mid rst busy", Busy, 0);
      check("mid rst strobes", {Start_Sum, Start_BgRemoval, Ack, Done, Err}, 0);
      check("mid rst exp", {red_exp, green_exp, blue_exp}, 0);
      check("mid rst no ack", n_ack - s_ack, 0);
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      check("post rst idle", Busy, 0);
      v = '{rs:{8'd13,8'd12,8'd11,8'd10}, gs:{8'd1,8'd2,8'd3,8'd6}, bs:{4{8'd77}},
            ws:2, wb:4, restart:0, sfull:1, bfull:1, er:11, eg:3, eb:77, eerr:0, elat:17, eack:2};
      check_frame("after_rst", v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
